rr_mux_n: RTL

Parametrised N-channel, W-bit registered stream multiplexer with round-robin arbitration and valid/ready handshakes on every port. It generalises the combinational `mux_n` select into a sequential block: the select comes from an internal fair arbiter instead of an input, and the output is registered. It sits between several producer streams and one shared consumer, for example several sources feeding one UART transmitter or one memory write port.

---
 rtl/rr_mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/rr_mux_n.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types for the round-robin stream multiplexer (rr_mux_n and rr_arbiter).
package rr_mux_pkg;

    typedef enum logic {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int SEL_W = $clog2(N);

    logic [SEL_W:0] idx_s;

    // Scan ptr+1 .. ptr+N; the explicit subtract keeps non-power-of-two N inside 0..N-1.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        idx_s        = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = {1'b0, ptr} + (SEL_W+1)'(k);
            if (idx_s >= (SEL_W+1)'(N)) begin
                idx_s = idx_s - (SEL_W+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!any && req[idx_s[SEL_W-1:0]]) begin
                any                             = 1'b1;
                grant_idx                       = idx_s[SEL_W-1:0];
                grant_onehot[idx_s[SEL_W-1:0]] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered stream mux with round-robin arbitration.
// Define RR_MUX_PACKET_EN to hold the grant on one channel until its in_last beat.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_sel,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] grant_idx_s;
    logic [N-1:0]     req_s;
    logic [N-1:0]     grant_onehot_s;
    logic             any_s;
    logic             can_load_s;
    logic             load_s;

`ifdef RR_MUX_PACKET_EN
    lock_state_t      state_r;
    logic [SEL_W-1:0] lock_ch_r;

    // While locked, present only the locked channel so the grant stays there even when it idles.
    always_comb begin
        req_s = '0;
        if (state_r == S_LOCKED) begin
            req_s[lock_ch_r] = 1'b1;
        end else begin
            req_s = in_valid;
        end
    end

    // Packet lock FSM: opens on reset or an accepted last beat, locks on a non-last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_OPEN;
            lock_ch_r <= {SEL_W{1'b0}};
        end else if (load_s) begin
            case (state_r)
                S_OPEN: begin
                    if (!in_last[grant_idx_s]) begin
                        state_r   <= S_LOCKED;
                        lock_ch_r <= grant_idx_s;
                    end else begin
                        state_r   <= S_OPEN;
                    end
                end
                S_LOCKED: begin
                    if (in_last[grant_idx_s]) begin
                        state_r <= S_OPEN;
                    end else begin
                        state_r <= S_LOCKED;
                    end
                end
                default: state_r <= S_OPEN;
            endcase
        end else begin
            state_r <= state_r;
        end
    end
`else
    // Per-beat arbitration: requests are the raw valids.
    always_comb begin
        req_s = in_valid;
    end
`endif

    rr_arbiter #(.N(N)) u_arb (
        .req          (req_s),
        .ptr          (ptr_r),
        .grant_onehot (grant_onehot_s),
        .grant_idx    (grant_idx_s),
        .any          (any_s)
    );

    assign can_load_s = !out_valid || out_ready;
    assign load_s     = !rst && any_s && can_load_s && in_valid[grant_idx_s];

    // out_ready reaches in_ready combinationally so a draining register can reload in the same cycle.
    always_comb begin
        if (!rst && can_load_s) begin
            in_ready = grant_onehot_s;
        end else begin
            in_ready = '0;
        end
    end

    // Output register and arbitration pointer; a load wins over a plain drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {W{1'b0}};
            out_sel   <= {SEL_W{1'b0}};
            out_last  <= 1'b0;
            ptr_r     <= SEL_W'(N-1);
        end else if (load_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx_s*W +: W];
            out_sel   <= grant_idx_s;
            out_last  <= in_last[grant_idx_s];
            ptr_r     <= grant_idx_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
